// File: rtl/pci_tgt_pkg.sv
// Shared definitions for the PCI user-target backends.
//
// Contents:
//   CMD_*            bit positions of the one-hot decoded PCI command bus
//   LEGAL_CMD_MASK   memory commands a memory-space BAR target accepts
//   WRITE_CMD_MASK   subset of the legal commands that move data into the target
//   tgt_state_e      target FSM state encoding
//   cmdAllowed()     true when the command is legal and matches the bus direction
package pci_tgt_pkg;

    localparam int CMD_MR  = 6;
    localparam int CMD_MW  = 7;
    localparam int CMD_MRM = 12;
    localparam int CMD_MRL = 14;
    localparam int CMD_MWI = 15;

    localparam logic [15:0] LEGAL_CMD_MASK = (16'h0001 << CMD_MR)  |
                                             (16'h0001 << CMD_MW)  |
                                             (16'h0001 << CMD_MRM) |
                                             (16'h0001 << CMD_MRL) |
                                             (16'h0001 << CMD_MWI);

    localparam logic [15:0] WRITE_CMD_MASK = (16'h0001 << CMD_MW) |
                                             (16'h0001 << CMD_MWI);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_XFER,
        ST_ABORT,
        ST_DONE
    } tgt_state_e;

    // A command is acceptable only if it is one of the memory commands and the
    // core's direction flag agrees with it (writes only for MW/MWI).
    function automatic logic cmdAllowed(input logic [15:0] cmd, input logic wrdn);
        logic isLegal;
        logic isWrite;
        isLegal = |(cmd & LEGAL_CMD_MASK);
        isWrite = |(cmd & WRITE_CMD_MASK);
        return isLegal && (isWrite == wrdn);
    endfunction

endpackage

// File: rtl/bar_ram_be.sv
// Word-addressed 32-bit RAM with per-byte write enables and asynchronous read.
//
// Ports:
//   clk_i    clock for the write port
//   we_i     one write enable per byte lane (bit n covers data[8n+7:8n])
//   addr_i   word address shared by the read and write ports
//   wdata_i  write data
//   rdata_o  combinational read of the addressed word
//
// Contents are never reset.
module bar_ram_be #(
    parameter int AW = 6
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:2**AW-1];

    // Each enabled lane overwrites its own byte; disabled lanes keep the
    // previous contents so partial-word writes merge in place.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // The core samples read data in the same cycle it completes a beat, so the
    // read path has no register.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bar_burst_target.sv
// Burst-capable memory-space target backend for one BAR of the PCI core's
// user target interface, backed by a 2**AW-word internal RAM.
//
// Ports:
//   CLK, RST_I   clock and synchronous active-high reset
//   s_wrdn       1 = write transaction, 0 = read
//   pci_cmd      one-hot decoded PCI command
//   addr         latched transaction start address
//   base_hit     one-cycle BAR hit pulse; only bit BAR_IDX is used
//   cbe_in       active-low byte enables, valid with s_data_vld
//   s_data       data-phase window active
//   s_data_vld   a data phase completes on the bus this cycle
//   adio_out     write data from the core
//   adio_in      read data to the core; high-Z when this target is not driving
//   s_ready      target ready (registered)
//   s_term       disconnect request (registered)
//   s_abort      target abort (registered)
module bar_burst_target
    import pci_tgt_pkg::*;
#(
    parameter int BAR_IDX     = 0,
    parameter int AW          = 6,
    parameter int WAIT_STATES = 2,
    parameter int MAX_BURST   = 16
) (
    input  logic        CLK,
    input  logic        RST_I,
    input  logic        s_wrdn,
    input  logic [15:0] pci_cmd,
    input  logic [31:0] addr,
    input  logic [7:0]  base_hit,
    input  logic [3:0]  cbe_in,
    input  logic        s_data,
    input  logic        s_data_vld,
    input  logic [31:0] adio_out,
    output logic [31:0] adio_in,
    output logic        s_ready,
    output logic        s_term,
    output logic        s_abort
);

    localparam logic [AW-1:0] IDX_LAST    = {AW{1'b1}};
    localparam logic [AW:0]   BURST_LIMIT = (AW+1)'(MAX_BURST);
    localparam logic [AW:0]   BURST_TERM  = (AW+1)'(MAX_BURST - 1);
    localparam logic [3:0]    WAIT_LAST   = 4'(WAIT_STATES - 1);

    tgt_state_e    state_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;
    logic [AW:0]   beats_q;
    logic [AW:0]   beats_d;
    logic [3:0]    wait_q;
    logic          dir_q;
    logic          winDone_q;
    logic          sData_q;
    logic          ready_q;
    logic          term_q;
    logic          abort_q;

    logic          hit;
    logic          reqOk;
    logic          sdFall;
    logic          beatTake;
    logic          termHit;
    logic [AW-1:0] startIdx;
    logic [3:0]    weLanes;
    logic [31:0]   ramRdata;
    logic          unusedBits;

    assign hit      = base_hit[BAR_IDX];
    assign startIdx = addr[AW+1:2];
    assign reqOk    = cmdAllowed(pci_cmd, s_wrdn) && (addr[1:0] == 2'b00);
    assign sdFall   = sData_q && !s_data;

    // Upper address bits and the other BARs' hit bits belong to other decoders.
    assign unusedBits = ^{addr[31:AW+2], base_hit};

    // A beat is consumed only while transferring, and only until either the
    // burst allowance is spent or the last RAM word has been used; later beats
    // are ignored so the index never wraps back to the start of the window.
    assign beatTake = (state_q == ST_XFER) && s_data_vld && !winDone_q &&
                      (beats_q != BURST_LIMIT);

    // Next index and beat count after the current cycle's beat, if any. The
    // index holds at the last word instead of wrapping.
    always_comb begin
        idx_d   = idx_q;
        beats_d = beats_q;
        if (beatTake) begin
            beats_d = beats_q + 1'b1;
            if (idx_q != IDX_LAST) begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Disconnect is requested from the cycle after the beat that leaves only
    // one more beat allowed, so the final beat completes with data.
    assign termHit = beatTake && ((idx_d == IDX_LAST) || (beats_d == BURST_TERM));

    // Entering transfer already sitting on the last word, or with a one-beat
    // allowance, means the very first beat is also the final one.
    function automatic logic termAtEntry(input logic [AW-1:0] idx);
        return (idx == IDX_LAST) || (MAX_BURST == 1);
    endfunction

    // Target FSM with all handshake outputs registered. The beat bookkeeping in
    // XFER runs before the s_data-fall transition, so a beat completing in the
    // same cycle as the window closing is still counted and written.
    always_ff @(posedge CLK) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            beats_q   <= '0;
            wait_q    <= '0;
            dir_q     <= 1'b0;
            winDone_q <= 1'b0;
            sData_q   <= 1'b0;
            ready_q   <= 1'b0;
            term_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            sData_q <= s_data;
            unique case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        idx_q     <= startIdx;
                        dir_q     <= s_wrdn;
                        wait_q    <= '0;
                        beats_q   <= '0;
                        winDone_q <= 1'b0;
                        if (!reqOk) begin
                            state_q <= ST_ABORT;
                            abort_q <= 1'b1;
                            term_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end else if (WAIT_STATES == 0) begin
                            state_q <= ST_XFER;
                            ready_q <= 1'b1;
                            term_q  <= termAtEntry(startIdx);
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sdFall) begin
                        state_q <= ST_IDLE;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= ST_XFER;
                        ready_q <= 1'b1;
                        term_q  <= termAtEntry(idx_q);
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                ST_XFER: begin
                    idx_q   <= idx_d;
                    beats_q <= beats_d;
                    if (beatTake && (idx_q == IDX_LAST)) begin
                        winDone_q <= 1'b1;
                    end
                    if (termHit) begin
                        term_q <= 1'b1;
                    end
                    if (sdFall) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b0;
                        term_q  <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    if (sdFall) begin
                        state_q <= ST_IDLE;
                        abort_q <= 1'b0;
                        term_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    term_q  <= 1'b0;
                    abort_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Write lanes follow the active-low byte enables. Reset suppresses the
    // write of a beat that coincides with it.
    assign weLanes = {4{beatTake && dir_q && !RST_I}} & ~cbe_in;

    bar_ram_be #(
        .AW (AW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (weLanes),
        .addr_i  (idx_q),
        .wdata_i (adio_out),
        .rdata_o (ramRdata)
    );

    // The read bus is shared with other targets, so it is only driven during a
    // read transfer while the core has the data window open.
    assign adio_in = ((state_q == ST_XFER) && !dir_q && s_data) ? ramRdata : 'z;

    assign s_ready = ready_q;
    assign s_term  = term_q;
    assign s_abort = abort_q;

endmodule
